// File: rtl/toggle_period_meter.sv
// Measures every half-period of a divided toggle signal in clk cycles,
// tracks lock against an expected half-period and flags lock loss / stuck input.
module toggle_period_meter #(
  parameter int unsigned W         = 23,
  parameter int unsigned N_EXP     = 1,
  parameter int unsigned TOL       = 0,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned STUCK_LIM = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tog_in,
  output logic         edge_strb,
  output logic         meas_valid,
  output logic [W-1:0] half_period,
  output logic         locked,
  output logic         err,
  output logic         stuck,
  output logic [15:0]  loss_count
);

  localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);

  // Match window evaluated two bits wider so N_EXP-TOL never underflows.
  localparam logic [W+1:0]   N_EXT     = (W+2)'(N_EXP);
  localparam logic [W+1:0]   TOL_EXT   = (W+2)'(TOL);
  localparam logic [W-1:0]   CNT_MAX   = {W{1'b1}};
  localparam logic [W-1:0]   STUCK_PRE = W'(STUCK_LIM - 1);
  localparam logic [MC_W-1:0] MC_LOCK  = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            tog_q_r;
  logic            tog_qq_r;
  logic [W-1:0]    cnt_r;
  logic [MC_W-1:0] match_cnt_r;

  logic            edge_s;
  logic            match_s;
  logic            stuck_hit_s;
  logic [W+1:0]    m_ext_s;
  logic [MC_W-1:0] match_inc_s;
  logic [MC_W-1:0] match_cnt_nxt_s;
  logic            meas_nxt_s;
  logic [W-1:0]    hp_nxt_s;
  logic            err_nxt_s;
  logic            stuck_nxt_s;
  logic            loss_inc_s;

  assign edge_s      = tog_q_r ^ tog_qq_r;
  assign m_ext_s     = {2'b00, cnt_r};
  assign match_s     = ((m_ext_s + TOL_EXT) >= N_EXT) && (m_ext_s <= (N_EXT + TOL_EXT));
  assign stuck_hit_s = (cnt_r == STUCK_PRE);
  assign match_inc_s = match_cnt_r + MC_W'(1);

  // Two-stage sampler; reset preloads the current input so release is edge-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q_r  <= tog_in;
      tog_qq_r <= tog_in;
    end else begin
      tog_q_r  <= tog_in;
      tog_qq_r <= tog_q_r;
    end
  end

  // Half-period counter, restarts at 1 on each edge and saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (edge_s) begin
      cnt_r <= W'(1);
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an edge always takes priority over the stuck timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          next_state_s = ACQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACQ: begin
        if (edge_s) begin
          if (match_s && (match_inc_s == MC_LOCK)) begin
            next_state_s = LOCKED;
          end else begin
            next_state_s = ACQ;
          end
        end else if (stuck_hit_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ACQ;
        end
      end
      LOCKED: begin
        if (edge_s) begin
          if (match_s) begin
            next_state_s = LOCKED;
          end else begin
            next_state_s = ACQ;
          end
        end else if (stuck_hit_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = LOCKED;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output / datapath next values derived from the current state and edge.
  always_comb begin
    match_cnt_nxt_s = match_cnt_r;
    meas_nxt_s      = 1'b0;
    hp_nxt_s        = half_period;
    err_nxt_s       = 1'b0;
    stuck_nxt_s     = stuck;
    loss_inc_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          match_cnt_nxt_s = {MC_W{1'b0}};
          stuck_nxt_s     = 1'b0;
        end else begin
          match_cnt_nxt_s = match_cnt_r;
        end
      end
      ACQ: begin
        if (edge_s) begin
          meas_nxt_s  = 1'b1;
          hp_nxt_s    = cnt_r;
          stuck_nxt_s = 1'b0;
          if (match_s) begin
            match_cnt_nxt_s = match_inc_s;
          end else begin
            match_cnt_nxt_s = {MC_W{1'b0}};
          end
        end else if (stuck_hit_s) begin
          stuck_nxt_s     = 1'b1;
          match_cnt_nxt_s = {MC_W{1'b0}};
        end else begin
          match_cnt_nxt_s = match_cnt_r;
        end
      end
      LOCKED: begin
        if (edge_s) begin
          meas_nxt_s  = 1'b1;
          hp_nxt_s    = cnt_r;
          stuck_nxt_s = 1'b0;
          if (match_s) begin
            match_cnt_nxt_s = match_cnt_r;
          end else begin
            err_nxt_s       = 1'b1;
            loss_inc_s      = 1'b1;
            match_cnt_nxt_s = {MC_W{1'b0}};
          end
        end else if (stuck_hit_s) begin
          stuck_nxt_s     = 1'b1;
          loss_inc_s      = 1'b1;
          match_cnt_nxt_s = {MC_W{1'b0}};
        end else begin
          match_cnt_nxt_s = match_cnt_r;
        end
      end
      default: begin
        match_cnt_nxt_s = {MC_W{1'b0}};
      end
    endcase
  end

  // Registered outputs and match counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_r <= {MC_W{1'b0}};
      edge_strb   <= 1'b0;
      meas_valid  <= 1'b0;
      half_period <= {W{1'b0}};
      locked      <= 1'b0;
      err         <= 1'b0;
      stuck       <= 1'b0;
      loss_count  <= 16'h0000;
    end else begin
      match_cnt_r <= match_cnt_nxt_s;
      edge_strb   <= edge_s;
      meas_valid  <= meas_nxt_s;
      half_period <= hp_nxt_s;
      locked      <= (next_state_s == LOCKED);
      err         <= err_nxt_s;
      stuck       <= stuck_nxt_s;
      if (loss_inc_s && (loss_count != 16'hFFFF)) begin
        loss_count <= loss_count + 16'h0001;
      end else begin
        loss_count <= loss_count;
      end
    end
  end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Randomized bench for toggle_period_meter: three instances with different
// parameters, each compared every cycle against an elapsed-time reference model.
module tb_toggle_period_meter;

  typedef struct packed {
    int   now;   // posedge index
    int   last;  // time origin of the running half-period
    logic s1;
    logic s2;
    int   prog;  // -1 idle, 0..LOCK-1 acquiring, LOCK locked
    logic eo;
    logic mv;
    logic lk;
    logic er;
    logic st;
    int   hp;
    int   loss;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog_a = 1'b0, tog_b = 1'b0, tog_c = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic ea, mva, lka, era, sta;
  logic eb, mvb, lkb, erb, stb;
  logic ec, mvc, lkc, erc, stc;
  logic [22:0] hpa, hpb, hpc;
  logic [15:0] lca, lcb, lcc;

  model_t ma = '0;
  model_t mb = '0;
  model_t mc = '0;

  always #5 clk = ~clk;

  toggle_period_meter #(.W(23), .N_EXP(5), .TOL(0), .LOCK_CNT(4), .STUCK_LIM(1024)) u_a (
    .clk(clk), .rst(rst), .tog_in(tog_a), .edge_strb(ea), .meas_valid(mva),
    .half_period(hpa), .locked(lka), .err(era), .stuck(sta), .loss_count(lca));

  toggle_period_meter #(.W(23), .N_EXP(5), .TOL(1), .LOCK_CNT(4), .STUCK_LIM(1024)) u_b (
    .clk(clk), .rst(rst), .tog_in(tog_b), .edge_strb(eb), .meas_valid(mvb),
    .half_period(hpb), .locked(lkb), .err(erb), .stuck(stb), .loss_count(lcb));

  toggle_period_meter #(.W(23), .N_EXP(1), .TOL(0), .LOCK_CNT(4), .STUCK_LIM(16)) u_c (
    .clk(clk), .rst(rst), .tog_in(tog_c), .edge_strb(ec), .meas_valid(mvc),
    .half_period(hpc), .locked(lkc), .err(erc), .stuck(stc), .loss_count(lcc));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference: m is the time elapsed since the last accepted edge.
  function automatic model_t mstep(model_t s, logic r, logic tog,
                                   int n_exp, int tol, int lock_cnt, int stuck_lim, int w);
    int   m;
    logic ev;
    logic match;
    if (r) begin
      s.s1 = tog; s.s2 = tog; s.prog = -1;
      s.eo = 1'b0; s.mv = 1'b0; s.lk = 1'b0; s.er = 1'b0; s.st = 1'b0;
      s.hp = 0; s.loss = 0;
      s.last = s.now + 1;
    end else begin
      ev = (s.s1 != s.s2);
      m  = s.now - s.last;
      if (m > (1 << w) - 1) m = (1 << w) - 1;
      s.eo = ev; s.mv = 1'b0; s.er = 1'b0;
      if (ev) begin
        s.st = 1'b0;
        if (s.prog < 0) begin
          s.prog = 0;
        end else begin
          s.mv  = 1'b1;
          s.hp  = m;
          match = (m >= n_exp - tol) && (m <= n_exp + tol);
          if (s.prog == lock_cnt) begin
            if (!match) begin
              s.er = 1'b1;
              if (s.loss < 65535) s.loss++;
              s.prog = 0;
            end
          end else begin
            s.prog = match ? s.prog + 1 : 0;
          end
        end
        s.last = s.now;
      end else if (s.prog >= 0 && m + 1 == stuck_lim) begin
        s.st = 1'b1;
        if (s.prog == lock_cnt && s.loss < 65535) s.loss++;
        s.prog = -1;
      end
      s.lk = (s.prog == lock_cnt);
      s.s2 = s.s1;
      s.s1 = tog;
    end
    s.now++;
    return s;
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, rst, tog_a, 5, 0, 4, 1024, 23);
    mb = mstep(mb, rst, tog_b, 5, 1, 4, 1024, 23);
    mc = mstep(mc, rst, tog_c, 1, 0, 4, 16, 23);
  end

  task automatic cmp_dut(input string p, input model_t m, input logic e, input logic mv,
                         input logic [22:0] hp, input logic lk, input logic er,
                         input logic st, input logic [15:0] lc);
    check_val({p, ".edge_strb"},  64'(e),  64'(m.eo));
    check_val({p, ".meas_valid"}, 64'(mv), 64'(m.mv));
    check_val({p, ".half_period"}, 64'(hp), 64'(m.hp));
    check_val({p, ".locked"},     64'(lk), 64'(m.lk));
    check_val({p, ".err"},        64'(er), 64'(m.er));
    check_val({p, ".stuck"},      64'(st), 64'(m.st));
    check_val({p, ".loss_count"}, 64'(lc), 64'(m.loss));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("a", ma, ea, mva, hpa, lka, era, sta, lca);
      cmp_dut("b", mb, eb, mvb, hpb, lkb, erb, stb, lcb);
      cmp_dut("c", mc, ec, mvc, hpc, lkc, erc, stc, lcc);
    end
  end

  // Toggle the selected input now, then hold it for n cycles.
  task automatic half(input int which, input int n);
    case (which)
      0:       tog_a = ~tog_a;
      1:       tog_b = ~tog_b;
      default: tog_c = ~tog_c;
    endcase
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int loss_before;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_val("reset.locked", 64'(lka), 64'd0);
    check_val("reset.loss",   64'(lca), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal lock on A
    repeat (8) half(0, 5);
    check_val("nom.locked", 64'(lka), 64'd1);
    check_val("nom.hp",     64'(hpa), 64'd5);
    check_val("nom.loss",   64'(lca), 64'd0);

    // Lock loss: one 7-cycle half-period
    half(0, 7);
    half(0, 5);
    check_val("loss.hp",     64'(hpa), 64'd7);
    check_val("loss.locked", 64'(lka), 64'd0);
    check_val("loss.count",  64'(lca), 64'd1);
    repeat (4) half(0, 5);
    check_val("loss.relock", 64'(lka), 64'd1);

    // Random half-periods on A
    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 5;
      half(0, n);
    end

    // Stuck input from lock
    repeat (6) half(0, 5);
    check_val("stk.pre_locked", 64'(lka), 64'd1);
    loss_before = ma.loss;
    half(0, 1100);
    check_val("stk.stuck",  64'(sta), 64'd1);
    check_val("stk.locked", 64'(lka), 64'd0);
    check_val("stk.loss",   64'(lca), 64'(loss_before + 1));
    half(0, 5);
    check_val("stk.cleared", 64'(sta), 64'd0);

    // Tolerance on B
    for (int i = 0; i < 8; i++) half(1, (i % 2 == 0) ? 4 : 6);
    check_val("tol.locked", 64'(lkb), 64'd1);
    check_val("tol.loss",   64'(lcb), 64'd0);
    repeat (10) half(1, 3);
    check_val("tol.unlocked",  64'(lkb), 64'd0);
    check_val("tol.match_cnt", 64'(u_b.match_cnt_r), 64'd0);
    for (int i = 0; i < 40; i++) half(1, int'($urandom_range(2, 8)));

    // N_EXP=1 boundary on C
    repeat (20) half(2, 1);
    check_val("n1.edge",   64'(ec),  64'd1);
    check_val("n1.locked", 64'(lkc), 64'd1);
    check_val("n1.hp",     64'(hpc), 64'd1);
    for (int i = 0; i < 60; i++) begin
      n = ($urandom_range(0, 9) == 0) ? 18 : int'($urandom_range(1, 2));
      half(2, n);
    end

    // Reset with tog_c high must not produce an edge afterwards
    if (tog_c == 1'b0) tog_c = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("rst_hi.edge", 64'(ec), 64'd0);
    end

    // Reset mid-acquisition on A
    repeat (3) half(0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid.mv",     64'(mva), 64'd0);
    check_val("mid.hp",     64'(hpa), 64'd0);
    check_val("mid.locked", 64'(lka), 64'd0);
    check_val("mid.stuck",  64'(sta), 64'd0);
    check_val("mid.loss",   64'(lca), 64'd0);
    repeat (4) half(0, 5);
    check_val("mid.not_yet", 64'(lka), 64'd0);
    half(0, 5);
    check_val("mid.locked2", 64'(lka), 64'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
